// File: rtl/mor1kx_trace_nop_pkg.sv
// rtl/mor1kx_trace_nop_pkg.sv - shared types and constants for l.nop trace event extraction
package mor1kx_trace_nop_pkg;

    // Widest timestamp an event entry can carry. The top zero-extends its counter into this field.
    localparam int EVT_TS_MAX_WIDTH = 64;

    // l.nop K encoding: opcode 6'h05 in insn[31:26], insn[25:24] == 2'b01, K in insn[15:0]
    localparam logic [5:0] OPC_NOP   = 6'h05;
    localparam logic [1:0] NOP_SUBOP = 2'b01;
    localparam logic [4:0] R3_IDX    = 5'd3;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        jb;
        logic        jal;
        logic        jr;
        logic [31:0] jbtarget;
        logic [31:0] insn;
        logic [31:0] wbdata;
        logic [4:0]  wbreg;
        logic        wben;
    } mor1kx_trace_exec_t;

    typedef struct packed {
        logic [EVT_TS_MAX_WIDTH-1:0] ts;
        logic [15:0]                 id;
        logic [31:0]                 value;
        logic                        lost;
    } trace_nop_event_t;

    // True for l.nop K with K != 0. l.nop 0 is the ordinary filler nop and never produces an event.
    function automatic logic is_nop_event(input logic [31:0] insn);
        return (insn[31:26] == OPC_NOP) && (insn[25:24] == NOP_SUBOP) && (insn[15:0] != 16'h0000);
    endfunction

endpackage

// File: rtl/trace_event_fifo.sv
// rtl/trace_event_fifo.sv - synchronous FIFO of trace_nop_event_t entries
module trace_event_fifo
    import mor1kx_trace_nop_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  trace_nop_event_t wdata_i,
    input  logic             pop_i,
    output trace_nop_event_t rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty can be told apart
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    trace_nop_event_t r_mem [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    assign empty_o   = (r_wr_ptr == r_rd_ptr);
    assign full_o    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = pop_i & ~empty_o;
    // When full, a push is only accepted together with a pop. It overwrites the slot being released.
    assign w_do_push = push_i & (~full_o | w_do_pop);

    // Head entry comes straight from storage. It reads as zero while the FIFO is empty so stale data never shows.
    assign rdata_o = empty_o ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; reset discards all stored entries
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset because the pointers define validity
    always_ff @(posedge clk_i) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/mor1kx_trace_nop_event.sv
// rtl/mor1kx_trace_nop_event.sv - extracts l.nop K software trace events from the mor1kx exec trace
module mor1kx_trace_nop_event
    import mor1kx_trace_nop_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int TS_WIDTH   = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 enable_i,
    input  mor1kx_trace_exec_t   trace_exec,
    output logic                 event_valid_o,
    input  logic                 event_ready_i,
    output logic [TS_WIDTH-1:0]  event_ts_o,
    output logic [15:0]          event_id_o,
    output logic [31:0]          event_value_o,
    output logic                 event_lost_o,
    output logic [CNT_WIDTH-1:0] drop_count_o
);

    logic [TS_WIDTH-1:0]  r_ts;
    logic [31:0]          r_r3;
    logic                 r_lost_pending;
    logic [CNT_WIDTH-1:0] r_drop_count;

    logic             w_detect;
    logic             w_r3_write;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    trace_nop_event_t w_entry;
    trace_nop_event_t w_head;
    logic             w_unused;

    assign w_detect   = trace_exec.valid & enable_i & is_nop_event(trace_exec.insn);
    assign w_r3_write = trace_exec.valid & trace_exec.wben & (trace_exec.wbreg == R3_IDX);

    assign w_pop  = ~w_empty & event_ready_i;
    assign w_push = w_detect & (~w_full | w_pop);
    assign w_drop = w_detect & w_full & ~w_pop;

    // The l.nop itself writes no register, so the shadow as of the previous cycle is the r3 value at retirement
    assign w_entry.ts    = EVT_TS_MAX_WIDTH'(r_ts);
    assign w_entry.id    = trace_exec.insn[15:0];
    assign w_entry.value = r_r3;
    assign w_entry.lost  = r_lost_pending;

    assign event_valid_o = ~w_empty;
    assign event_ts_o    = w_head.ts[TS_WIDTH-1:0];
    assign event_id_o    = w_head.id;
    assign event_value_o = w_head.value;
    assign event_lost_o  = w_head.lost;
    assign drop_count_o  = r_drop_count;

    // Trace fields outside the nop/writeback decode, and the spare timestamp bits, are intentionally ignored
    assign w_unused = ^{trace_exec, w_head.ts};

    trace_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_push),
        .wdata_i (w_entry),
        .pop_i   (w_pop),
        .rdata_o (w_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    // Free-running timestamp and r3 shadow, both independent of enable_i
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_ts <= '0;
            r_r3 <= '0;
        end else begin
            r_ts <= r_ts + TS_WIDTH'(1);
            if (w_r3_write) r_r3 <= trace_exec.wbdata;
        end
    end

    // Overflow bookkeeping: flag the next stored event and count drops, saturating at all-ones
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_lost_pending <= 1'b0;
            r_drop_count   <= '0;
        end else begin
            if (w_push) begin
                r_lost_pending <= 1'b0;
            end else if (w_drop) begin
                r_lost_pending <= 1'b1;
            end
            if (w_drop && (r_drop_count != '1)) begin
                r_drop_count <= r_drop_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_mor1kx_trace_nop_event.sv
// tb/tb_mor1kx_trace_nop_event.sv - self-checking bench for mor1kx_trace_nop_event
module tb_mor1kx_trace_nop_event;
    import mor1kx_trace_nop_pkg::*;

    logic               clk_i;
    logic               rst_ni;
    logic               enable_i;
    mor1kx_trace_exec_t trace_exec;
    logic               event_valid_o;
    logic               event_ready_i;
    logic [31:0]        event_ts_o;
    logic [15:0]        event_id_o;
    logic [31:0]        event_value_o;
    logic               event_lost_o;
    logic [15:0]        drop_count_o;

    mor1kx_trace_nop_event #(
        .FIFO_DEPTH (8),
        .TS_WIDTH   (32),
        .CNT_WIDTH  (16)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .enable_i      (enable_i),
        .trace_exec    (trace_exec),
        .event_valid_o (event_valid_o),
        .event_ready_i (event_ready_i),
        .event_ts_o    (event_ts_o),
        .event_id_o    (event_id_o),
        .event_value_o (event_value_o),
        .event_lost_o  (event_lost_o),
        .drop_count_o  (drop_count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] ts;
        logic [15:0] id;
        logic [31:0] value;
        logic        lost;
    } ev_t;

    ev_t         m_q[$];
    logic [31:0] m_ts;
    logic [31:0] m_r3;
    logic        m_lost;
    logic [15:0] m_drops;
    bit          m_known;

    int n_checks;
    int n_errors;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        trace_exec = '0;
    endtask

    task automatic set_nop(input logic [15:0] k);
        trace_exec       = '0;
        trace_exec.valid = 1'b1;
        trace_exec.pc    = $urandom;
        trace_exec.insn  = {8'h15, 8'h00, k};
    endtask

    task automatic set_wr(input logic [4:0] rd, input logic [31:0] val);
        trace_exec        = '0;
        trace_exec.valid  = 1'b1;
        trace_exec.pc     = $urandom;
        trace_exec.insn   = {6'h2a, rd, 5'd0, 16'h1234};
        trace_exec.wben   = 1'b1;
        trace_exec.wbreg  = rd;
        trace_exec.wbdata = val;
    endtask

    // Compare outputs against the model, advance the model by this cycle's inputs, then clock once
    task automatic step();
        bit   pop;
        bit   det;
        bit   full_before;
        ev_t  e;
        if (m_known) begin
            chk("valid", event_valid_o, m_q.size() != 0);
            if (m_q.size() != 0) begin
                chk("ts", event_ts_o, m_q[0].ts);
                chk("id", event_id_o, m_q[0].id);
                chk("value", event_value_o, m_q[0].value);
                chk("lost", event_lost_o, m_q[0].lost);
            end
            chk("drop_count", drop_count_o, m_drops);
        end
        if (!rst_ni) begin
            m_q.delete();
            m_ts    = 0;
            m_r3    = 0;
            m_lost  = 0;
            m_drops = 0;
            m_known = 1;
        end else begin
            pop         = (m_q.size() != 0) && event_ready_i;
            det         = trace_exec.valid && enable_i &&
                          (trace_exec.insn[31:24] == 8'h15) && (trace_exec.insn[15:0] != 0);
            full_before = (m_q.size() == 8);
            if (pop) void'(m_q.pop_front());
            if (det) begin
                if (!full_before || pop) begin
                    e.ts    = m_ts;
                    e.id    = trace_exec.insn[15:0];
                    e.value = m_r3;
                    e.lost  = m_lost;
                    m_q.push_back(e);
                    m_lost = 0;
                end else begin
                    m_lost = 1;
                    if (m_drops != 16'hffff) m_drops++;
                end
            end
            if (trace_exec.valid && trace_exec.wben && trace_exec.wbreg == 5'd3) m_r3 = trace_exec.wbdata;
            m_ts = m_ts + 1;
        end
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_known  = 0;
        m_ts     = 0;
        m_r3     = 0;
        m_lost   = 0;
        m_drops  = 0;

        // Reset state
        rst_ni        = 1'b0;
        enable_i      = 1'b1;
        event_ready_i = 1'b0;
        set_idle();
        step();
        step();
        rst_ni = 1'b1;
        chk("rst_valid", event_valid_o, 0);
        chk("rst_ts", event_ts_o, 0);
        chk("rst_id", event_id_o, 0);
        chk("rst_value", event_value_o, 0);
        chk("rst_lost", event_lost_o, 0);
        chk("rst_drop", drop_count_o, 0);

        // r3 write then l.nop 4: one event, one cycle later
        event_ready_i = 1'b1;
        set_wr(5'd3, 32'hDEADBEEF);
        step();
        set_nop(16'h0004);
        step();
        set_idle();
        chk("t1_valid", event_valid_o, 1);
        chk("t1_id", event_id_o, 16'h0004);
        chk("t1_value", event_value_o, 32'hDEADBEEF);
        chk("t1_lost", event_lost_o, 0);
        step();
        step();

        // l.nop 0 and disabled l.nop 1 produce nothing; shadow follows r3 even while disabled
        set_nop(16'h0000);
        step();
        enable_i = 1'b0;
        set_wr(5'd3, 32'h11111111);
        step();
        set_nop(16'h0001);
        step();
        enable_i = 1'b1;
        set_idle();
        chk("t2_none", event_valid_o, 0);
        set_nop(16'h0007);
        step();
        set_idle();
        chk("t2_shadow", event_value_o, 32'h11111111);
        step();
        step();

        // Overflow: 10 events into 8 entries with consumer stalled
        event_ready_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            set_nop(16'h0001);
            step();
        end
        set_idle();
        step();
        chk("t3_drops", drop_count_o, 2);
        // Full, consumer ready, new event: pop and push together, no drop, new entry carries lost
        event_ready_i = 1'b1;
        set_nop(16'h0022);
        step();
        set_idle();
        chk("t4_drops", drop_count_o, 2);
        for (int i = 0; i < 10; i++) step();

        // Randomised traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            int sel;
            enable_i      = ($urandom_range(0, 7) != 0);
            event_ready_i = $urandom_range(0, 1);
            sel           = $urandom_range(0, 5);
            case (sel)
                0: set_idle();
                1, 2: set_nop(($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom));
                3: set_wr(5'd3, $urandom);
                4: set_wr(5'($urandom_range(0, 31)), $urandom);
                default: begin
                    trace_exec        = '0;
                    trace_exec.valid  = $urandom_range(0, 1);
                    trace_exec.insn   = $urandom;
                    trace_exec.wben   = $urandom_range(0, 1);
                    trace_exec.wbreg  = 5'($urandom_range(0, 31));
                    trace_exec.wbdata = $urandom;
                end
            endcase
            step();
        end

        // Reset with queued events discards everything
        enable_i      = 1'b1;
        event_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_nop(16'h0100 + 16'(i));
            step();
        end
        set_idle();
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        chk("t6_valid", event_valid_o, 0);
        chk("t6_drops", drop_count_o, 0);
        event_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
